mac_seq_ctrl: RTL
=================

Name: mac_seq_ctrl

Overview:
- Sequencer for the 8-bit multiply-accumulate datapath (product register, accumulator register, bias/feedback mux).
- Accepts an input sample stream (valid/ready) and supplies the matching coefficient from an internal coefficient register file.
- Drives the datapath enables `r1_enable`, `r2_enable` and `m_enable`, then presents each finished frame result downstream with `m_tvalid`/`m_tready`.
- Sits between the sample source and the datapath. Sample data goes straight to the datapath `i_TDATA`; this block only gates it.

Parameters:
- `DW`, default 8: coefficient/data width. Must match the datapath width.
- `N_MAX`, default 16: maximum taps per frame, which is also the coefficient file depth.
- `LEN_W`, default `$clog2(N_MAX+1)`: width of `cfg_len`.
- `AW`, default `$clog2(N_MAX)`: coefficient address width.

Ports:
- `clk`, in, 1: clock. All logic is rising-edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `cfg_len`, in, `LEN_W`: taps per frame. Sampled at the first handshake of a frame.
- `cfg_we`, in, 1: coefficient write strobe.
- `cfg_addr`, in, `AW`: coefficient write address.
- `cfg_wdata`, in, `DW`: coefficient write data.
- `s_tvalid`, in, 1: upstream sample valid.
- `s_tready`, out, 1: sample accepted this cycle when `s_tvalid` is also high.
- `s_tlast`, in, 1: upstream end-of-frame marker. Used only with the optional feature.
- `k_TDATA`, out, `DW`: coefficient for the current tap, driven to the datapath.
- `r1_enable`, out, 1: datapath product-register load.
- `r2_enable`, out, 1: datapath accumulator load.
- `m_enable`, out, 1: datapath mux select (1 = bias `b_TDATA`, 0 = accumulator feedback).
- `m_tvalid`, out, 1: qualifies the datapath output `o_TDATA` as the frame result.
- `m_tready`, in, 1: downstream accepts the result.
- `busy`, out, 1: state is not IDLE.
- `frame_err`, out, 1: sticky frame-length mismatch flag. Used only with the optional feature.

Behaviour:
- Reset (async, `reset`=0): state goes to IDLE, all coefficients are set to 0, `tap_idx`/`len_q` are set to 0, and all outputs are 0.
- FSM states: IDLE, RUN, DRAIN, HOLD.
- IDLE:
  - `s_tready = (cfg_len != 0)`.
  - On the first handshake, latch `len_q = min(cfg_len, N_MAX)`, set `tap_idx` to 0, and go to RUN, or to DRAIN if `len_q` = 1.
- RUN:
  - `s_tready` = 1.
  - Each handshake increments `tap_idx`.
  - The handshake that accepts tap `len_q-1` goes to DRAIN.
  - Upstream gaps (`s_tvalid`=0) stall without side effects.
- DRAIN: `s_tready` = 0. Lasts one cycle, for the final accumulate, then goes to HOLD.
- HOLD:
  - `m_tvalid` = 1 and `s_tready` = 0.
  - Holds until `m_tready` = 1, then returns to IDLE; `m_tvalid` drops the next cycle.
  - `o_TDATA` stays stable because `r2_enable` is 0.
- Enable generation:
  - `r1_enable = s_tvalid & s_tready`, combinational, in the same cycle as the handshake.
  - `k_TDATA = coef[tap_idx]`, combinational read.
  - `r2_enable` is `r1_enable` registered by one cycle.
  - `m_enable` is registered by one cycle as (`r1_enable` and `tap_idx`==0), so the first tap adds the bias and later taps add feedback.
- Result: `o_TDATA = b_TDATA + sum(i_n * k_n)`. Every product and sum is truncated mod 2^`DW` (datapath width), with no saturation.
- Latency: `m_tvalid` rises 2 cycles after the last-tap handshake.
- Throughput: one tap per cycle. Gap between frames is at least 2 cycles plus the `m_tready` wait.
- `cfg_len` = 0: the block stays in IDLE with `s_tready` = 0. `cfg_len` > `N_MAX` is clamped to `N_MAX`.
- `cfg_len` changes mid-frame are ignored; `len_q` governs the frame.
- `cfg_we` is honoured only in IDLE and ignored otherwise. A write and a handshake in the same IDLE cycle: the read uses the old value.
- `b_TDATA` must be stable from the first handshake until DRAIN; this is the source's responsibility.
- Reset mid-frame: immediate abort with no result, and coefficients are cleared.

Optional Feature:
- Macro: `MAC_SEQ_CTRL_TLAST_CHECK_EN`.
- Defined:
  - `frame_err` is set and held until reset if `s_tlast` = 1 on a handshake other than the last tap, or `s_tlast` = 0 on the last-tap handshake.
  - Frame sequencing is unchanged and always governed by `len_q`.
- Undefined: `s_tlast` is ignored and `frame_err` is tied to 0. Both ports remain present.

Decomposition:
- Package `mac_seq_pkg`: `state_t` enum (IDLE, RUN, DRAIN, HOLD), default `DW`/`N_MAX` localparams, and a clamp function for `len`.
- Sub-module `mac_coef_rf`: `N_MAX`x`DW` register file with async active-low clear, synchronous write, and combinational read. It is instantiated once.

Test Plan:
- Basic frame, with coefficients {1,2,3}, `cfg_len`=3, `b_TDATA`=5, samples 4,5,6 sent back-to-back:
  - `r1_enable` is high for 3 cycles and `m_enable` pulses once, at the first `r2_enable`.
  - `m_tvalid` rises 2 cycles after the third handshake, with `o_TDATA`=37.
- Same frame with 2-cycle `s_tvalid` bubbles between samples: `r1_enable` is high only on handshakes and `o_TDATA`=37.
- Backpressure, with `m_tready`=0 for 10 cycles: `m_tvalid`=1, `s_tready`=0 and `o_TDATA` stable. After `m_tready`=1, `busy` falls and the next frame starts cleanly.
- Wrap: coefficient 16, sample 16, `len`=1, bias 3 gives `o_TDATA`=3. Coefficients {255,255}, samples {1,1}, bias 2 gives `o_TDATA`=0.
- Length edges:
  - `cfg_len`=0 keeps `s_tready`=0 for 20 cycles.
  - `cfg_len`=20 results in exactly 16 handshakes.
  - `cfg_we` while `busy` leaves the coefficient unchanged.
- Reset asserted after 2 of 3 taps gives all outputs 0 and IDLE. A replayed frame with bias 9 gives `o_TDATA`=9, since coefficients were cleared. With the macro, early `s_tlast` on tap 1 of 3 sets `frame_err`=1.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and defaults for the MAC sequencer slice.
package mac_seq_pkg;

   localparam int unsigned DW_DEF    = 8;
   localparam int unsigned N_MAX_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // Limit a requested frame length to the coefficient file depth.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned n_max);
      return (len > n_max) ? n_max : len;
   endfunction

endpackage

// File: rtl/mac_coef_rf.sv
// Coefficient register file: async clear, synchronous write, combinational read.
module mac_coef_rf #(
   parameter int unsigned DW    = 8,
   parameter int unsigned N_MAX = 16,
   parameter int unsigned AW    = $clog2(N_MAX)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [N_MAX];

   // Storage: cleared on reset, one write port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(N_MAX); i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the 8-bit MAC datapath: gates samples, supplies coefficients,
// drives the product/accumulator/mux enables and hands the frame result downstream.
// Optional: define MAC_SEQ_CTRL_TLAST_CHECK_EN to flag s_tlast/length mismatches on frame_err.
module mac_seq_ctrl
   import mac_seq_pkg::*;
#(
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned N_MAX = N_MAX_DEF,
   parameter int unsigned LEN_W = $clog2(N_MAX + 1),
   parameter int unsigned AW    = $clog2(N_MAX)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [DW-1:0]    cfg_wdata,
   input  logic             s_tvalid,
   output logic             s_tready,
   input  logic             s_tlast,
   output logic [DW-1:0]    k_TDATA,
   output logic             r1_enable,
   output logic             r2_enable,
   output logic             m_enable,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             busy,
   output logic             frame_err
);

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len_q, len_nxt, len_c;
   logic [AW-1:0]    tap_idx, tap_nxt;
   logic             hs, is_last, coef_we, err_nxt;

   assign len_c = LEN_W'(clamp_len(32'(cfg_len), N_MAX));

   // Sample acceptance; held low while reset is asserted so every output reads 0.
   assign s_tready  = reset && (((state == IDLE) && (cfg_len != '0)) || (state == RUN));
   assign hs        = s_tvalid & s_tready;
   assign r1_enable = hs;
   assign coef_we   = cfg_we & (state == IDLE);

   mac_coef_rf #(
      .DW    (DW),
      .N_MAX (N_MAX),
      .AW    (AW)
   ) u_coef_rf (
      .clk   (clk),
      .reset (reset),
      .we    (coef_we),
      .waddr (cfg_addr),
      .wdata (cfg_wdata),
      .raddr (tap_idx),
      .rdata (k_TDATA)
   );

   // Next-state, frame length and tap index.
   always_comb begin
      state_nxt = state;
      len_nxt   = len_q;
      tap_nxt   = tap_idx;
      is_last   = 1'b0;
      unique case (state)
         IDLE: begin
            is_last = (len_c == LEN_W'(1));
            if (hs) begin
               len_nxt   = len_c;
               tap_nxt   = is_last ? '0 : AW'(1);
               state_nxt = is_last ? DRAIN : RUN;
            end
         end
         RUN: begin
            is_last = (LEN_W'(tap_idx) == (len_q - LEN_W'(1)));
            if (hs) begin
               tap_nxt = is_last ? '0 : tap_idx + AW'(1);
               if (is_last) state_nxt = DRAIN;
            end
         end
         DRAIN:   state_nxt = HOLD;
         HOLD:    if (m_tready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef MAC_SEQ_CTRL_TLAST_CHECK_EN
   // Sticky error when the marker disagrees with the latched frame length.
   assign err_nxt = frame_err | (hs & (s_tlast != is_last));
`else
   logic unused_tlast;
   assign unused_tlast = s_tlast;
   assign err_nxt      = 1'b0;
`endif

   // State and registered outputs; enables lag the handshake by one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         len_q     <= '0;
         tap_idx   <= '0;
         r2_enable <= 1'b0;
         m_enable  <= 1'b0;
         m_tvalid  <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         len_q     <= len_nxt;
         tap_idx   <= tap_nxt;
         r2_enable <= hs;
         m_enable  <= hs && (tap_idx == '0);
         m_tvalid  <= (state_nxt == HOLD);
         busy      <= (state_nxt != IDLE);
         frame_err <= err_nxt;
      end
   end

endmodule
